serial_frame_receiver: RTL and testbench



---
 rtl/serial_frame_receiver.sv | 126 ++++++++++++
 tb/tb_serial_frame_receiver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Bits are sampled only on enableShift strobes; a good frame yields a one-cycle dataValid.
module serial_frame_receiver (
  input  logic       clockpulse,
  input  logic       clear,
  input  logic       enableShift,
  input  logic       serialInput,
  input  logic       enableParity,
  output logic [7:0] dataOut,
  output logic       dataValid,
  output logic       parityError,
  output logic       frameError,
  output logic       busy,
  output logic [3:0] frameCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_mode_q, parity_mode_d;
  logic        run_par_q, run_par_d;
  logic        line_high_q, line_high_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        parity_error_q, parity_error_d;
  logic        frame_error_q, frame_error_d;
  logic [3:0]  frame_count_q, frame_count_d;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    parity_mode_d  = parity_mode_q;
    run_par_d      = run_par_q;
    line_high_d    = line_high_q;
    data_out_d     = data_out_q;
    data_valid_d   = 1'b0;
    parity_error_d = parity_error_q;
    frame_error_d  = 1'b0;
    frame_count_d  = frame_count_q;

    if (enableShift) begin
      unique case (state_q)
        IDLE: begin
          // A start bit counts only once the line has been seen idle-high.
          if (serialInput) begin
            line_high_d = 1'b1;
          end else if (line_high_q) begin
            state_d       = DATA;
            bit_cnt_d     = '0;
            parity_mode_d = enableParity;
            run_par_d     = 1'b0;
          end
        end
        DATA: begin
          shift_d   = {serialInput, shift_q[7:1]};
          run_par_d = run_par_q ^ serialInput;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = parity_mode_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          run_par_d = run_par_q ^ serialInput;
          state_d   = STOP;
        end
        STOP: begin
          state_d     = IDLE;
          line_high_d = serialInput;
          if (serialInput) begin
            data_out_d     = shift_q;
            data_valid_d   = 1'b1;
            parity_error_d = parity_mode_q & run_par_q;
            frame_count_d  = frame_count_q + 4'd1;
          end else begin
            frame_error_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clockpulse) begin
    if (clear) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      parity_mode_q  <= 1'b0;
      run_par_q      <= 1'b0;
      line_high_q    <= 1'b0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      parity_mode_q  <= parity_mode_d;
      run_par_q      <= run_par_d;
      line_high_q    <= line_high_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign dataOut     = data_out_q;
  assign dataValid   = data_valid_q;
  assign parityError = parity_error_q;
  assign frameError  = frame_error_q;
  assign busy        = (state_q != IDLE);
  assign frameCount  = frame_count_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver: stimulus pushes expected frame results,
// a negedge monitor pops and compares them whenever dataValid or frameError is seen.
module tb_serial_frame_receiver;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       enableShift = 1'b0;
  logic       serialInput = 1'b1;
  logic       enableParity = 1'b0;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       parityError;
  logic       frameError;
  logic       busy;
  logic [3:0] frameCount;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       fe;
    logic [7:0] d;
    logic       pe;
    logic [3:0] fc;
  } exp_t;

  exp_t exp_q[$];

  serial_frame_receiver dut (
    .clockpulse  (clk),
    .clear       (clear),
    .enableShift (enableShift),
    .serialInput (serialInput),
    .enableParity(enableParity),
    .dataOut     (dataOut),
    .dataValid   (dataValid),
    .parityError (parityError),
    .frameError  (frameError),
    .busy        (busy),
    .frameCount  (frameCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare every output event against the scoreboard head.
  initial begin
    logic prev_pulse;
    exp_t e;
    prev_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_pulse) begin
        check("pulse_width_valid", {31'd0, dataValid}, 32'd0);
        check("pulse_width_ferr", {31'd0, frameError}, 32'd0);
      end
      if (dataValid || frameError) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, dataValid, frameError}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("mon_dataValid", {31'd0, dataValid}, {31'd0, !e.fe});
          check("mon_frameError", {31'd0, frameError}, {31'd0, e.fe});
          check("mon_dataOut", {24'd0, dataOut}, {24'd0, e.d});
          check("mon_parityError", {31'd0, parityError}, {31'd0, e.pe});
          check("mon_frameCount", {28'd0, frameCount}, {28'd0, e.fc});
        end
      end
      prev_pulse = dataValid | frameError;
    end
  end

  task automatic push(input logic fe, input logic [7:0] d, input logic pe, input logic [3:0] fc);
    exp_t e;
    e.fe = fe; e.d = d; e.pe = pe; e.fc = fc;
    exp_q.push_back(e);
  endtask

  task automatic strobe(input logic b, input int gap);
    serialInput = b;
    enableShift = 1'b1;
    @(posedge clk); #1;
    enableShift = 1'b0;
    serialInput = 1'b1;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // pause_after: data-bit index after which strobes stop for 20 clocks (-1 = none).
  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                            input logic stop, input int gap, input int pause_after,
                            input logic clr_at_stop);
    enableParity = par_en;
    strobe(1'b0, gap);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      strobe(d[i], gap);
      if (i == pause_after) begin
        enableParity = ~par_en;
        repeat (20) begin @(posedge clk); #1; end
        check("busy_during_pause", {31'd0, busy}, 32'd1);
      end
    end
    if (par_en) strobe(par_bit, gap);
    clear = clr_at_stop;
    strobe(stop, 0);
    clear = 1'b0;
    check("busy_after_stop", {31'd0, busy}, 32'd0);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dataOut"}, {24'd0, dataOut}, 32'd0);
    check({tag, "_flags"}, {28'd0, dataValid, parityError, frameError, busy}, 32'd0);
    check({tag, "_frameCount"}, {28'd0, frameCount}, 32'd0);
  endtask

  initial begin
    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset_initial");
    clear = 1'b0;
    // lineHigh is 0 after reset: a start bit now is ignored.
    strobe(1'b0, 3);
    check("start_ignored_after_reset", {31'd0, busy}, 32'd0);
    strobe(1'b1, 3);

    // No parity, 8'hA5.
    push(1'b0, 8'hA5, 1'b0, 4'd1);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 3, -1, 1'b0);

    // Parity on, 8'h03: correct bit 0, then wrong bit 1.
    push(1'b0, 8'h03, 1'b0, 4'd2);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 3, -1, 1'b0);
    push(1'b0, 8'h03, 1'b1, 4'd3);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 3, -1, 1'b0);

    // Stop bit 0 after 8'hFF: frame error, outputs otherwise held.
    push(1'b1, 8'h03, 1'b1, 4'd3);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 3, -1, 1'b0);
    repeat (3) strobe(1'b0, 1);
    check("no_start_after_frame_error", {31'd0, busy}, 32'd0);
    check("count_held_after_frame_error", {28'd0, frameCount}, 32'd3);
    strobe(1'b1, 1);

    // Strobes paused 20 clocks mid-DATA; enableParity flips during the frame.
    push(1'b0, 8'h3C, 1'b0, 4'd4);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1, 3, 1'b0);
    enableParity = 1'b0;

    // Reset mid-frame.
    strobe(1'b0, 1);
    strobe(1'b1, 1);
    strobe(1'b0, 1);
    strobe(1'b1, 1);
    clear = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    clear = 1'b0;
    check_reset_values("reset_midframe");
    strobe(1'b0, 1);
    check("start_ignored_after_midframe_reset", {31'd0, busy}, 32'd0);
    strobe(1'b1, 0);

    // 16 back-to-back frames with continuous strobes: count wraps to 0.
    for (int i = 0; i < 16; i++) begin
      push(1'b0, 8'(i * 17), 1'b0, 4'((i + 1) % 16));
      send_frame(8'(i * 17), 1'b0, 1'b0, 1'b1, 0, -1, 1'b0);
    end
    @(posedge clk); #1;
    check("count_wrapped", {28'd0, frameCount}, 32'd0);
    check("dataOut_last_b2b", {24'd0, dataOut}, 32'hFF);

    // clear on the stop-bit edge wins: no pulse, no increment.
    strobe(1'b1, 1);
    send_frame(8'h77, 1'b0, 1'b0, 1'b1, 1, -1, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    check_reset_values("reset_at_stop");

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
